// File: rtl/vec_pkg.sv
// vec_pkg
// Shared definitions for the vector register bank slice.
//  - Default geometry: VEC_WIDTH bits per element, VEC_LANES elements per
//    register, VEC_NREGS registers.
//  - Streaming-load FSM state encoding (plain constants so that older tools
//    and the legacy register datapath can share them).
//  - laneLsb: bit offset of a lane inside a packed vector.
package vec_pkg;

  localparam int VEC_WIDTH = 16;
  localparam int VEC_LANES = 4;
  localparam int VEC_NREGS = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Lane i of a packed vector occupies bits [i*width +: width].
  function automatic int laneLsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/vec_ld_fsm.sv
// vec_ld_fsm
// Control for the lane-serial streaming load engine. Holds the state, the
// lane counter and the latched target register, and produces the handshake
// outputs plus the per-cycle stream write strobe for the storage array.
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_ld_start, i_ld_addr  start a load into register i_ld_addr (IDLE only)
//   i_ld_abort             abandon the load in progress
//   i_ld_valid             streamed element is valid
//   o_ld_ready/busy/done   handshake and status outputs
//   o_ld_we                write ld_data into lane o_cnt of register o_tgt
//   o_tgt, o_cnt           current target register and lane
module vec_ld_fsm
  import vec_pkg::*;
#(
  parameter int LANES = VEC_LANES,
  parameter int NREGS = VEC_NREGS,
  parameter int AW    = $clog2(NREGS),
  parameter int CW    = $clog2(LANES)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_ld_start,
  input  logic [AW-1:0] i_ld_addr,
  input  logic          i_ld_abort,
  input  logic          i_ld_valid,
  output logic          o_ld_ready,
  output logic          o_ld_busy,
  output logic          o_ld_done,
  output logic          o_ld_we,
  output logic [AW-1:0] o_tgt,
  output logic [CW-1:0] o_cnt
);

  localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_tgt;

  // The counter is left at the last lane on the final handshake rather than
  // incremented, so it never wraps inside a load; ld_start clears it anyway.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_tgt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_ld_start) begin
            r_tgt   <= i_ld_addr;
            r_cnt   <= '0;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (i_ld_abort) begin
            r_state <= ST_IDLE;
          end else if (i_ld_valid) begin
            if (r_cnt == LAST_LANE) begin
              r_state <= ST_DONE;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ld_busy  = (r_state == ST_LOAD);
  assign o_ld_ready = (r_state == ST_LOAD);
  assign o_ld_done  = (r_state == ST_DONE);
  // Abort wins over a simultaneous handshake: nothing is written that cycle.
  assign o_ld_we    = o_ld_busy && i_ld_valid && !i_ld_abort;
  assign o_tgt      = r_tgt;
  assign o_cnt      = r_cnt;

endmodule

// File: rtl/vec_reg_bank.sv
// vec_reg_bank
// Bank of NREGS vector registers, LANES elements of WIDTH bits each.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   wea, waddr, wmask, datain parallel masked write of a whole vector
//   ld_start, ld_addr,        lane-serial streaming load with valid/ready
//   ld_abort, ld_data,        handshake; ld_busy while loading, ld_done
//   ld_valid, ld_ready,       pulses one cycle when a load completes
//   ld_busy, ld_done
//   raddr_a/dataout_a,        two combinational read ports, no bypass
//   raddr_b/dataout_b
module vec_reg_bank
  import vec_pkg::*;
#(
  parameter int WIDTH = VEC_WIDTH,
  parameter int LANES = VEC_LANES,
  parameter int NREGS = VEC_NREGS,
  parameter int AW    = $clog2(NREGS),
  parameter int CW    = $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wea,
  input  logic [AW-1:0]          waddr,
  input  logic [LANES-1:0]       wmask,
  input  logic [LANES*WIDTH-1:0] datain,
  input  logic                   ld_start,
  input  logic [AW-1:0]          ld_addr,
  input  logic                   ld_abort,
  input  logic [WIDTH-1:0]       ld_data,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  output logic                   ld_busy,
  output logic                   ld_done,
  input  logic [AW-1:0]          raddr_a,
  output logic [LANES*WIDTH-1:0] dataout_a,
  input  logic [AW-1:0]          raddr_b,
  output logic [LANES*WIDTH-1:0] dataout_b
);

  logic [LANES*WIDTH-1:0] r_bank [NREGS];

  logic          w_ldWe;
  logic [AW-1:0] w_tgt;
  logic [CW-1:0] w_cnt;
  logic          w_parWe;

  vec_ld_fsm #(
    .LANES (LANES),
    .NREGS (NREGS),
    .AW    (AW),
    .CW    (CW)
  ) u_ld_fsm (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_ld_start (ld_start),
    .i_ld_addr  (ld_addr),
    .i_ld_abort (ld_abort),
    .i_ld_valid (ld_valid),
    .o_ld_ready (ld_ready),
    .o_ld_busy  (ld_busy),
    .o_ld_done  (ld_done),
    .o_ld_we    (w_ldWe),
    .o_tgt      (w_tgt),
    .o_cnt      (w_cnt)
  );

  // While a load is running the stream owns its target register: a parallel
  // write aimed there is dropped entirely, even on lanes the stream has not
  // reached yet. Writes to other registers go ahead alongside the stream.
  assign w_parWe = wea && !(ld_busy && (waddr == w_tgt));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) begin
        r_bank[r] <= '0;
      end
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (w_parWe && wmask[l]) begin
          r_bank[waddr][laneLsb(l, WIDTH) +: WIDTH] <= datain[laneLsb(l, WIDTH) +: WIDTH];
        end
        if (w_ldWe && (w_cnt == CW'(l))) begin
          r_bank[w_tgt][laneLsb(l, WIDTH) +: WIDTH] <= ld_data;
        end
      end
    end
  end

  assign dataout_a = r_bank[raddr_a];
  assign dataout_b = r_bank[raddr_b];

endmodule

// File: tb/tb_vec_reg_bank.sv
// tb_vec_reg_bank
// Directed bench for vec_reg_bank at the default geometry (16-bit elements,
// 4 lanes, 4 registers). Inputs change just after the falling edge and
// outputs are compared at the following falling edge, so each step() covers
// exactly one rising edge of the DUT.
module tb_vec_reg_bank;

  logic        clk;
  logic        rst;
  logic        wea;
  logic [1:0]  waddr;
  logic [3:0]  wmask;
  logic [63:0] datain;
  logic        ld_start;
  logic [1:0]  ld_addr;
  logic        ld_abort;
  logic [15:0] ld_data;
  logic        ld_valid;
  logic        ld_ready;
  logic        ld_busy;
  logic        ld_done;
  logic [1:0]  raddr_a;
  logic [63:0] dataout_a;
  logic [1:0]  raddr_b;
  logic [63:0] dataout_b;

  int assertCount = 0;
  int failCount   = 0;

  vec_reg_bank dut (
    .clk       (clk),
    .rst       (rst),
    .wea       (wea),
    .waddr     (waddr),
    .wmask     (wmask),
    .datain    (datain),
    .ld_start  (ld_start),
    .ld_addr   (ld_addr),
    .ld_abort  (ld_abort),
    .ld_data   (ld_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_busy   (ld_busy),
    .ld_done   (ld_done),
    .raddr_a   (raddr_a),
    .dataout_a (dataout_a),
    .raddr_b   (raddr_b),
    .dataout_b (dataout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Compares the three load handshake outputs in one go as {ready,busy,done}.
  task automatic checkStatus(input string tag, input logic [2:0] expected);
    checkOutput(tag, {61'd0, ld_ready, ld_busy, ld_done}, {61'd0, expected});
  endtask

  task automatic applyStimulus();
    // Reset and initial read-back.
    rst = 1'b0; wea = 1'b0; waddr = '0; wmask = '0; datain = '0;
    ld_start = 1'b0; ld_addr = '0; ld_abort = 1'b0; ld_data = '0; ld_valid = 1'b0;
    raddr_a = 2'd0; raddr_b = 2'd3;
    step(); step();
    rst = 1'b1;
    #1;
    checkOutput("reset_dout_a", dataout_a, 64'h0);
    checkOutput("reset_dout_b", dataout_b, 64'h0);
    checkStatus("reset_status", 3'b000);

    // Masked parallel write to reg2; visible only after the edge.
    step();
    wea = 1'b1; waddr = 2'd2; wmask = 4'b0101;
    datain = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
    raddr_a = 2'd2;
    #1;
    checkOutput("par_before_edge", dataout_a, 64'h0);
    step();
    checkOutput("par_masked", dataout_a, 64'h0000_CCCC_0000_AAAA);
    // An empty mask writes nothing.
    wmask = 4'b0000; datain = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    wea = 1'b0;
    checkOutput("par_zero_mask", dataout_a, 64'h0000_CCCC_0000_AAAA);

    // Streaming load into reg1 with one idle cycle between elements 2 and 3.
    ld_valid = 1'b1; ld_data = 16'h9999;
    step();
    checkOutput("valid_in_idle", dataout_a, 64'h0000_CCCC_0000_AAAA);
    ld_valid = 1'b0;
    ld_start = 1'b1; ld_addr = 2'd1; raddr_a = 2'd1;
    step();
    ld_start = 1'b0;
    checkStatus("load_entered", 3'b110);
    ld_valid = 1'b1; ld_data = 16'h0011;
    step();
    ld_data = 16'h0022;
    step();
    ld_valid = 1'b0;
    checkOutput("stream_partial", dataout_a, 64'h0000_0000_0022_0011);
    checkStatus("stream_partial_st", 3'b110);
    step();
    checkStatus("stream_gap_st", 3'b110);
    ld_valid = 1'b1; ld_data = 16'h0033;
    step();
    ld_data = 16'h0044;
    step();
    ld_valid = 1'b0;
    checkStatus("stream_done_pulse", 3'b001);
    checkOutput("stream_full", dataout_a, 64'h0044_0033_0022_0011);
    step();
    checkStatus("stream_back_idle", 3'b000);

    // Collision: writes to the stream target are dropped, others go ahead.
    ld_start = 1'b1; ld_addr = 2'd1; raddr_b = 2'd3;
    step();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 16'h0101;
    wea = 1'b1; waddr = 2'd1; wmask = 4'b1111; datain = 64'hEEEE_EEEE_EEEE_EEEE;
    step();
    checkOutput("coll_tgt_blocked", dataout_a, 64'h0044_0033_0022_0101);
    waddr = 2'd3; datain = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    ld_data = 16'h0202;
    step();
    wea = 1'b0;
    checkOutput("coll_other_reg", dataout_b, 64'h4444_3333_2222_1111);
    checkOutput("coll_stream_reg", dataout_a, 64'h0044_0033_0202_0101);
    ld_data = 16'h0303;
    step();
    ld_data = 16'h0404;
    step();
    ld_valid = 1'b0;
    checkStatus("coll_done", 3'b001);
    checkOutput("coll_final", dataout_a, 64'h0404_0303_0202_0101);
    step();

    // Abort after two elements into reg0.
    ld_start = 1'b1; ld_addr = 2'd0; raddr_a = 2'd0;
    step();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 16'h1111;
    step();
    ld_data = 16'h2222;
    step();
    ld_data = 16'h3333; ld_abort = 1'b1;
    step();
    ld_abort = 1'b0; ld_valid = 1'b0;
    checkStatus("abort_idle", 3'b000);
    checkOutput("abort_kept", dataout_a, 64'h0000_0000_2222_1111);
    ld_start = 1'b1; ld_addr = 2'd2;
    step();
    checkStatus("restart_accepted", 3'b110);
    // A second start while busy must not retarget the load.
    ld_addr = 2'd3;
    step();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 16'h0A0A; raddr_a = 2'd2;
    step();
    ld_valid = 1'b0;
    checkOutput("busy_start_ignored", dataout_a, 64'h0000_CCCC_0000_0A0A);
    checkOutput("busy_start_reg3", dataout_b, 64'h4444_3333_2222_1111);

    // Asynchronous reset in the middle of the load.
    #2;
    rst = 1'b0;
    #1;
    checkStatus("midreset_status", 3'b000);
    checkOutput("midreset_dout_a", dataout_a, 64'h0);
    step();
    rst = 1'b1;
    step();
    checkStatus("post_reset_status", 3'b000);
    for (int r = 0; r < 4; r++) begin
      raddr_a = 2'(r);
      #1;
      checkOutput($sformatf("post_reset_reg%0d", r), dataout_a, 64'h0);
    end
  endtask

  initial begin
    applyStimulus();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/vec_reg_bank.md
Name: vec_reg_bank

Overview:
- Parametrised successor to the single 16-bit data register: a bank of NREGS vector registers, each holding LANES elements of WIDTH bits.
- Provides a full-vector parallel write port with a per-lane mask, and a lane-serial streaming load engine with a valid/ready handshake for memory-to-register transfers.
- Provides two combinational read ports.
- Sits between the memory interface and the vector ALU in the memory-to-memory datapath.

Parameters:
- WIDTH, 16: bits per element.
- LANES, 4: elements per vector register; must be at least 2.
- NREGS, 4: number of vector registers; must be at least 2.
- AW, $clog2(NREGS): register address width (derived).
- CW, $clog2(LANES): lane counter width (derived).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wea  in  1  parallel write enable.
- waddr  in  AW  parallel write register address.
- wmask  in  LANES  per-lane write mask; bit i gates lane i.
- datain  in  LANES*WIDTH  parallel write data; lane i occupies bits [i*WIDTH +: WIDTH].
- ld_start  in  1  start a streaming load.
- ld_addr  in  AW  target register for the streaming load.
- ld_abort  in  1  abandon the streaming load in progress.
- ld_data  in  WIDTH  streamed element.
- ld_valid  in  1  ld_data is valid.
- ld_ready  out  1  engine accepts ld_data this cycle.
- ld_busy  out  1  a load is in progress (LOAD state).
- ld_done  out  1  one-cycle pulse when a load completes.
- raddr_a  in  AW  read port A address.
- dataout_a  out  LANES*WIDTH  read port A data (combinational).
- raddr_b  in  AW  read port B address.
- dataout_b  out  LANES*WIDTH  read port B data (combinational).

Behaviour:
- Reset (rst=0, asynchronous):
  - All register contents are 0.
  - FSM goes to IDLE and the lane counter to 0.
  - ld_ready=0, ld_busy=0, ld_done=0.
  - dataout_a and dataout_b read 0.
  - Reset asserted mid-load abandons the load with no ld_done pulse.
- Reads: dataout_x = bank[raddr_x], purely combinational, no bypass. A write becomes visible the cycle after the clock edge that performs it.
- Parallel write: on a clock edge with wea=1, every lane i with wmask[i]=1 of bank[waddr] takes datain lane i. Other lanes are unchanged. wmask=0 writes nothing.
- FSM states:
  - IDLE: ld_ready=0. On ld_start=1, latch ld_addr into tgt, set cnt=0, go to LOAD.
  - LOAD: ld_busy=1, ld_ready=1.
    - When ld_valid & ld_ready: write ld_data into bank[tgt] lane cnt and increment cnt.
    - If cnt==LANES-1 at that handshake, go to DONE.
    - ld_abort=1 has priority: go to IDLE, write nothing that cycle, keep lanes already written, no ld_done.
  - DONE: ld_done=1 for exactly this cycle, ld_ready=0, then IDLE unconditionally.
- ld_start outside IDLE is ignored. ld_start in DONE is also ignored; the earliest restart is the next cycle.
- Minimum load latency: ld_start edge, then LANES handshake cycles, then the ld_done cycle. With valid held high the total is LANES+2 cycles from ld_start to the IDLE return.
- Collision rules:
  - wea to waddr==tgt while ld_busy=1 is fully suppressed for that cycle, so the stream owns the target register.
  - wea to any other register proceeds in the same cycle as a stream write.
- ld_valid in IDLE or DONE is ignored and no data is written.
- The counter never wraps inside a load; it is cleared to 0 on each ld_start.

Decomposition:
- Shared package vec_pkg holds:
  - WIDTH, LANES and NREGS defaults;
  - the FSM state encoding (IDLE=2'd0, LOAD=2'd1, DONE=2'd2);
  - the lane-slice helper function.
- One natural sub-module, vec_ld_fsm, holds the state, counter, tgt latch and handshake outputs.
- vec_reg_bank holds the storage array, write arbitration and read muxes.

Test Plan:
- Reset then read: rst=0 for 2 cycles, then rst=1; raddr_a=0, raddr_b=3 → both dataouts are 0, and ld_ready, ld_busy and ld_done are 0.
- Masked parallel write: wea=1, waddr=2, wmask=4'b0101, datain={16'hDDDD,16'hCCCC,16'hBBBB,16'hAAAA} → next cycle dataout_a@2 = {16'h0000,16'hCCCC,16'h0000,16'hAAAA}.
- Streaming load with gaps: ld_start with ld_addr=1, then valid elements 16'h0011, 16'h0022, 16'h0033, 16'h0044 with one idle cycle between the 2nd and 3rd → reg1 = {16'h0044,16'h0033,16'h0022,16'h0011}; ld_done pulses exactly once, the cycle after the 4th handshake.
- Collision: during a load to reg1, wea=1 to waddr=1 and in the same cycle to waddr=3 → reg1 holds only stream data; reg3 is written.
- Abort: ld_start to reg0, 2 elements (16'h1111, 16'h2222), then ld_abort → IDLE with no ld_done; reg0 = {0,0,16'h2222,16'h1111}; a new ld_start is accepted next cycle.
- Reset mid-load: rst=0 after 1 handshake → all registers 0, FSM IDLE, no ld_done; ld_start while busy is ignored (tgt unchanged).
